regfile_pipe: RTL and testbench

- Parametrised successor to the single-cycle 16x16 register file.
- Sits between instruction fetch and the ALU stage.
- Decodes the operand fields of an incoming instruction, reads two operands and presents them, with opcode and destination, as a registered decode-stage output.
- Adds: a dedicated write-address port, write-to-read bypass, an immediate (Type B) operand mode, a valid/stall handshake, and a hardwired-zero register 0.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_bypass_read.sv | 15 +
 rtl/regfile_pipe.sv | 70 +++++++
 tb/tb_regfile_pipe.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, field positions and reset contents for the pipelined register file
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int IMM_W_DEF = 8;
  localparam logic [3:0] TYPEA_OPC = 4'hF;
  localparam int OPC_LSB = 12;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 4;
  typedef logic [DATA_W_DEF-1:0] word_t;
  function automatic word_t regfile_init(input int unsigned idx);
    case (idx)
      1: regfile_init = 16'h0F00;
      2: regfile_init = 16'h0050;
      3: regfile_init = 16'hFF0F;
      4: regfile_init = 16'hF0FF;
      5: regfile_init = 16'h0040;
      6: regfile_init = 16'h6666;
      7: regfile_init = 16'h00FF;
      8: regfile_init = 16'hFF88;
      12: regfile_init = 16'hCCCC;
      13: regfile_init = 16'h0002;
      default: regfile_init = 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/regfile_bypass_read.sv
// regfile_bypass_read: one read port with hardwired-zero r0 and same-cycle write forwarding
module regfile_bypass_read #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_q,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] data
);
  // r0 wins over forwarding so a write aimed at index 0 can never leak through
  always_comb data = (addr == '0) ? '0 : (we && wa == addr) ? wd : reg_q;
endmodule

// File: rtl/regfile_pipe.sv
// regfile_pipe: decode-stage register file with bypass, immediate operands and valid/stall handshake
module regfile_pipe
  import regfile_pkg::*;
#(
  parameter int         DATA_W    = DATA_W_DEF,
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         IMM_W     = IMM_W_DEF,
  parameter logic [3:0] TYPEA_OPC = regfile_pkg::TYPEA_OPC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruc_in,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] Writedata,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] dest,
  output logic              out_valid
);
  localparam int DEPTH = 2 ** ADDR_W;
  if (IMM_W > DATA_W || ADDR_W > 4) begin : g_bad_params
    $error("regfile_pipe: IMM_W must not exceed DATA_W and ADDR_W must not exceed 4");
  end
  logic [DATA_W-1:0] regs [DEPTH];
  logic [3:0]        opc;
  logic [ADDR_W-1:0] rs1, rs2;
  logic [DATA_W-1:0] rd1, rd2, imm_ext, op2_nxt;
  assign opc = instruc_in[OPC_LSB +: 4];
  assign rs1 = instruc_in[RS1_LSB +: ADDR_W];
  assign rs2 = instruc_in[RS2_LSB +: ADDR_W];
  assign imm_ext = DATA_W'($signed(instruc_in[IMM_W-1:0]));
  regfile_bypass_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr(rs1), .reg_q(regs[rs1]), .we(RegWrite), .wa(wr_addr), .wd(Writedata), .data(rd1)
  );
  regfile_bypass_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr(rs2), .reg_q(regs[rs2]), .we(RegWrite), .wa(wr_addr), .wd(Writedata), .data(rd2)
  );
  // Type A takes the second register, every other opcode takes the sign-extended immediate
  always_comb op2_nxt = (opc == TYPEA_OPC) ? rd2 : imm_ext;
  // Register array: reset reloads the init table, writes ignore stall/valid and never touch r0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (DATA_W == 16) ? DATA_W'(regfile_init(i)) : '0;
    end else if (RegWrite && wr_addr != '0) begin
      regs[wr_addr] <= Writedata;
    end
  end
  // Decode stage: stall freezes everything, a bubble drops out_valid but keeps the data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op1       <= '0;
      op2       <= '0;
      opcode    <= 4'h0;
      dest      <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= instr_valid;
      if (instr_valid) begin
        op1    <= rd1;
        op2    <= op2_nxt;
        opcode <= opc;
        dest   <= rs1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_pipe.sv
// tb_regfile_pipe: directed-vector bench for the decode-stage register file
module tb_regfile_pipe;
  typedef struct packed {
    logic [15:0] instr;
    logic        valid;
    logic        stl;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [40:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruc_in = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        RegWrite = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] Writedata = '0;
  logic [15:0] op1, op2;
  logic [3:0]  opcode, dest;
  logic        out_valid;
  logic [40:0] obs;
  int vectors = 0;
  int miscompares = 0;
  assign obs = {op1, op2, opcode, dest, out_valid};
  always #5 clk = ~clk;
  regfile_pipe dut (
    .clk(clk), .reset(reset), .instruc_in(instruc_in), .instr_valid(instr_valid),
    .stall(stall), .RegWrite(RegWrite), .wr_addr(wr_addr), .Writedata(Writedata),
    .op1(op1), .op2(op2), .opcode(opcode), .dest(dest), .out_valid(out_valid)
  );
  task automatic step(input vec_t t);
    instruc_in = t.instr;
    instr_valid = t.valid;
    stall = t.stl;
    RegWrite = t.we;
    wr_addr = t.wa;
    Writedata = t.wd;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    vec_t v [5];
    reset = 1'b0;
    #1;
    if (obs !== 41'h0) begin $display("FAIL reset_initial got %h exp %h", obs, 41'h0); miscompares++; end
    vectors++;
    #4 reset = 1'b1;
    step('{16'hF120, 1'b1, 1'b0, 1'b1, 4'h1, 16'hAAAA, {16'hAAAA, 16'h0050, 4'hF, 4'h1, 1'b1}});
    if (obs !== {16'hAAAA, 16'h0050, 4'hF, 4'h1, 1'b1}) begin $display("FAIL pre_reset_write got %h exp %h", obs, {16'hAAAA, 16'h0050, 4'hF, 4'h1, 1'b1}); miscompares++; end
    vectors++;
    #2 reset = 1'b0;
    #1;
    if (obs !== 41'h0) begin $display("FAIL reset_midstream got %h exp %h", obs, 41'h0); miscompares++; end
    vectors++;
    #1 reset = 1'b1;
    v = '{
      '{16'hF120, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'h0F00, 16'h0050, 4'hF, 4'h1, 1'b1}},
      '{16'hF780, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'h00FF, 16'hFF88, 4'hF, 4'h7, 1'b1}},
      '{16'hFCD0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'hCCCC, 16'h0002, 4'hF, 4'hC, 1'b1}},
      '{16'hF9A0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'h0000, 16'h0000, 4'hF, 4'h9, 1'b1}},
      '{16'hFBF0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'h0000, 16'h0000, 4'hF, 4'hB, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL reset_init_table[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  task automatic test_type_b;
    vec_t v [4];
    v = '{
      '{16'h23F0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'hFF0F, 16'hFFF0, 4'h2, 4'h3, 1'b1}},
      '{16'h2305, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'hFF0F, 16'h0005, 4'h2, 4'h3, 1'b1}},
      '{16'h0480, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'hF0FF, 16'hFF80, 4'h0, 4'h4, 1'b1}},
      '{16'hE57F, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, {16'h0040, 16'h007F, 4'hE, 4'h5, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL type_b[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  task automatic test_bypass;
    vec_t v [4];
    v = '{
      '{16'hF560, 1'b1, 1'b0, 1'b1, 4'h5, 16'h1234, {16'h1234, 16'h6666, 4'hF, 4'h5, 1'b1}},
      '{16'hF550, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h1234, 16'h1234, 4'hF, 4'h5, 1'b1}},
      '{16'hF560, 1'b1, 1'b0, 1'b1, 4'h6, 16'hABCD, {16'h1234, 16'hABCD, 4'hF, 4'h5, 1'b1}},
      '{16'hF660, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'hABCD, 16'hABCD, 4'hF, 4'h6, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL bypass[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  task automatic test_reg_zero;
    vec_t v [2];
    v = '{
      '{16'hF010, 1'b1, 1'b0, 1'b1, 4'h0, 16'hFFFF, {16'h0000, 16'h0F00, 4'hF, 4'h0, 1'b1}},
      '{16'hF010, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h0000, 16'h0F00, 4'hF, 4'h0, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL reg_zero[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  task automatic test_stall;
    vec_t v [7];
    v = '{
      '{16'hF120, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h0F00, 16'h0050, 4'hF, 4'h1, 1'b1}},
      '{16'hF340, 1'b1, 1'b1, 1'b1, 4'h1, 16'h5555, {16'h0F00, 16'h0050, 4'hF, 4'h1, 1'b1}},
      '{16'h2305, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, {16'h0F00, 16'h0050, 4'hF, 4'h1, 1'b1}},
      '{16'hF560, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, {16'h0F00, 16'h0050, 4'hF, 4'h1, 1'b1}},
      '{16'hF340, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'hFF0F, 16'hF0FF, 4'hF, 4'h3, 1'b1}},
      '{16'hF100, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h5555, 16'h0000, 4'hF, 4'h1, 1'b1}},
      '{16'hF110, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h5555, 16'h5555, 4'hF, 4'h1, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL stall[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  task automatic test_bubble;
    vec_t v [3];
    v = '{
      '{16'h2305, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h5555, 16'h5555, 4'hF, 4'h1, 1'b0}},
      '{16'hF340, 1'b0, 1'b0, 1'b1, 4'h3, 16'h7777, {16'h5555, 16'h5555, 4'hF, 4'h1, 1'b0}},
      '{16'h2305, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, {16'h7777, 16'h0005, 4'h2, 4'h3, 1'b1}}
    };
    foreach (v[i]) begin
      step(v[i]);
      if (obs !== v[i].exp) begin $display("FAIL bubble[%0d] got %h exp %h", i, obs, v[i].exp); miscompares++; end
      vectors++;
    end
  endtask
  initial begin
    #2;
    test_reset;
    test_type_b;
    test_bypass;
    test_reg_zero;
    test_stall;
    test_bubble;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
